pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Fetch sequencer that drives the next-PC input (pc_prima) and update enable of the program counter register.
- Runs a handshake with instruction memory and selects among sequential (PC+4), branch-target and halt flows.
- Sits between the program counter and instruction memory; the control unit reports branch, stall and halt events to it.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.
- IRQ_VECTOR, 32'h0000_0018, interrupt target address (used only with PCSEQ_IRQ_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- branch_valid  input  1  taken branch reported for the instruction currently issued.
- branch_target  input  32  branch destination address.
- stall  input  1  pipeline stall request; holds the current instruction.
- halt  input  1  stop fetching after the current instruction.
- imem_ready  input  1  instruction memory has the data for imem_addr.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equals pc.
- instr_valid  output  1  fetched instruction is valid this cycle.
- pc  output  32  current program counter.
- pc_prima  output  32  next PC value presented to the program counter register.
- pc_en  output  1  program counter update enable.
- halted  output  1  sequencer is in the HALTED state.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; pc=RESET_VECTOR; pc_prima=RESET_VECTOR.
  - imem_req, instr_valid, pc_en and halted are 0; the pending-branch flag is cleared.
  - Outputs change immediately, without waiting for a clock edge, including mid-fetch.
- States: IDLE, FETCH, ISSUE, HALTED.
- IDLE: one cycle after reset release, then go to FETCH. All outputs are inactive.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Stay in FETCH while imem_ready=0.
  - On imem_ready=1, go to ISSUE on the next edge. If a branch is pending, go to FETCH on the new pc instead.
- ISSUE:
  - instr_valid=1 for exactly one cycle unless stall=1.
  - While stall=1: stay in ISSUE, instr_valid held at 1, pc_en=0, pc unchanged.
  - With stall=0:
    - pc_prima = branch_valid ? {branch_target[31:2],2'b00} : pc+PC_STEP.
    - pc_en=1; pc<=pc_prima at the edge.
    - Next state is HALTED if halt=1, otherwise FETCH.
- Priority when several inputs are active in ISSUE: stall > branch_valid > sequential. With halt and branch_valid both set and stall=0, pc is updated to the branch target and the state goes to HALTED.
- HALTED:
  - halted=1; imem_req=0; pc frozen.
  - Only reset exits this state; branch_valid, halt and imem_ready are ignored.
- Pending branch: branch_valid=1 during FETCH sets the pending flag and loads pc with the aligned target at that edge.
  - The in-flight fetch completes at imem_ready.
  - That instruction is discarded (instr_valid stays 0) and FETCH restarts at the new pc.
  - A second branch_valid while the flag is pending overwrites the target.
- Arithmetic: PC_STEP addition is modulo 2^32, so 32'hFFFF_FFFC + 4 gives 32'h0000_0000. No overflow flag.
- Latency:
  - First imem_req is asserted 1 cycle after reset release.
  - With imem_ready=1 in the same cycle as the request, each instruction takes 2 cycles (FETCH, ISSUE).
- Outside ISSUE, pc_prima=pc (hold) and pc_en=0, except for the pending-branch load.

Optional Feature:
- PCSEQ_IRQ_EN defined:
  - Adds input irq (1), output irq_ack (1) and output epc (32).
  - irq=1 sampled in ISSUE with stall=0 has top priority over branch_valid:
    - epc<=pc_prima as computed without the irq.
    - pc<=IRQ_VECTOR.
    - irq_ack=1 for one cycle.
  - In any other state, irq is held off until the next ISSUE.
  - epc resets to 0.
- PCSEQ_IRQ_EN undefined: the irq, irq_ack and epc ports do not exist, and behaviour is exactly as above.

Test Plan:
- Reset release, imem_ready tied to 1 → imem_req rises 1 cycle later; pc sequence 0x0, 0x4, 0x8; instr_valid every 2nd cycle.
- In ISSUE at pc=0x0F0C: branch_valid=1, branch_target=0xECAB → pc becomes 0xECA8; next imem_addr=0xECA8.
- stall=1 for 3 cycles in ISSUE at pc=0x10 → pc stays 0x10, instr_valid held 3 cycles, pc_en=0; advances to 0x14 after stall drops.
- branch_valid=1 during FETCH with imem_ready delayed 2 cycles → fetched instruction discarded (no instr_valid); next fetch at the target.
- pc=0xFFFF_FFFC, sequential issue → pc wraps to 0x0. halt=1 in ISSUE → halted=1, imem_req stays 0 for 10 cycles.
- reset asserted mid-FETCH with imem_ready=0 → imem_req drops immediately; pc=RESET_VECTOR before the next clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer that owns the program counter, runs the
// request/ready handshake with instruction memory and chooses between the
// sequential, branch and halt flows.
// Optional feature macro: PCSEQ_IRQ_EN adds irq / irq_ack / epc and the
// IRQ_VECTOR parameter; with the macro undefined none of these exist.
//
// Handshake: imem_req is held high with imem_addr == pc for as long as the
// sequencer is in FETCH; a cycle with imem_req=1 and imem_ready=1 completes the
// fetch at the next rising edge. imem_ready is ignored whenever imem_req=0.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
`ifdef PCSEQ_IRQ_EN
  , parameter logic [31:0] IRQ_VECTOR = 32'h0000_0018
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        halt,
  input  logic        imem_ready,
`ifdef PCSEQ_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] epc,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_prima,
  output logic        pc_en,
  output logic        halted,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_ISSUE  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic        pend_q, pend_d;
  logic [31:0] br_aligned;
  logic [31:0] seq_pc;
  logic [31:0] issue_next;
  logic        unused_bt_lsb;

  // Branch targets are word aligned by dropping the low two bits.
  assign br_aligned    = {branch_target[31:2], 2'b00};
  assign seq_pc        = pc_q + 32'(PC_STEP);
  assign issue_next    = branch_valid ? br_aligned : seq_pc;
  assign unused_bt_lsb = ^branch_target[1:0];

  // State, pending-branch flag and pc register; reset acts immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (pc_en) begin
        pc_q <= pc_prima;
      end
    end
  end

  // Next-state logic: a fetch completing while a branch is pending (or
  // arriving in that same cycle) is thrown away and FETCH restarts at pc.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          pend_d  = 1'b0;
          state_d = (pend_q || branch_valid) ? S_FETCH : S_ISSUE;
        end else begin
          pend_d  = pend_q | branch_valid;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          state_d = halt ? S_HALTED : S_FETCH;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef PCSEQ_IRQ_EN
  logic [31:0] epc_q, epc_d;

  // Exception PC captured when an interrupt is taken in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= 32'h0000_0000;
    end else begin
      epc_q <= epc_d;
    end
  end

  assign epc = epc_q;
`endif

  // Output decode; outside ISSUE pc holds unless a branch lands during FETCH.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_en       = 1'b0;
    halted      = 1'b0;
    pc_prima    = pc_q;
`ifdef PCSEQ_IRQ_EN
    irq_ack     = 1'b0;
    epc_d       = epc_q;
`endif
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (branch_valid) begin
          pc_en    = 1'b1;
          pc_prima = br_aligned;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          pc_en    = 1'b1;
          pc_prima = issue_next;
`ifdef PCSEQ_IRQ_EN
          if (irq) begin
            epc_d    = issue_next;
            pc_prima = IRQ_VECTOR;
            irq_ack  = 1'b1;
          end
`endif
        end
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign state_dbg = state_q;

endmodule
